// File: rtl/apb_bridge_arbiter_if.sv
// Two-master request bundle plus the shared bridge-side request and grant/ack returns.
interface apb_bridge_arbiter_if;
  logic        req0;
  logic        req1;
  logic        Hwrite0;
  logic        Hwrite1;
  logic [31:0] Haddr0;
  logic [31:0] Haddr1;
  logic [31:0] Hwdata0;
  logic [31:0] Hwdata1;
  logic        Hreadyout;
  logic        valid;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [1:0]  gnt;
  logic        ack0;
  logic        ack1;

  // arbiter side
  modport slave (
    input  req0, req1, Hwrite0, Hwrite1, Haddr0, Haddr1, Hwdata0, Hwdata1, Hreadyout,
    output valid, Hwrite, Haddr, Hwdata, gnt, ack0, ack1
  );

  // masters plus bridge, as seen from outside the arbiter
  modport master (
    output req0, req1, Hwrite0, Hwrite1, Haddr0, Haddr1, Hwdata0, Hwdata1, Hreadyout,
    input  valid, Hwrite, Haddr, Hwdata, gnt, ack0, ack1
  );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// Two-master arbiter in front of a single AHB-to-APB bridge: round-robin on ties,
// bounded bursts per ownership, no switching while the bridge is busy.
//
// state | meaning
// IDLE  | no owner, gnt=00, bridge request driven to zero
// OWN0  | master0 owns the bridge, gnt=01
// OWN1  | master1 owns the bridge, gnt=10
module apb_bridge_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic                 clk,
  input logic                 rst,
  apb_bridge_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic       last_owner;
  logic [3:0] cnt;
  logic       own_req;
  logic       oth_req;
  state_t     other;

  assign own_req = (state == OWN0) ? bus.req0 : bus.req1;
  assign oth_req = (state == OWN0) ? bus.req1 : bus.req0;
  assign other   = (state == OWN0) ? OWN1 : OWN0;

  // state encoding doubles as the registered grant vector
  assign bus.gnt = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            cnt        <= 4'd0;
          end else if (bus.req1) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            cnt        <= 4'd0;
          end
        end
        OWN0, OWN1: begin
          // bridge busy: owner, count and mux selection are all frozen
          if (bus.Hreadyout) begin
            if (own_req) begin
              if (cnt == BURST_LAST) begin
                cnt <= 4'd0;
                if (oth_req) begin
                  state      <= other;
                  last_owner <= (state == OWN0);
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else if (oth_req) begin
              state      <= other;
              last_owner <= (state == OWN0);
              cnt        <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.valid  = 1'b0;
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'd0;
    bus.Hwdata = 32'd0;
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    case (state)
      OWN0: begin
        bus.valid  = bus.req0;
        bus.Hwrite = bus.Hwrite0;
        bus.Haddr  = bus.Haddr0;
        bus.Hwdata = bus.Hwdata0;
        bus.ack0   = bus.req0 && bus.Hreadyout;
      end
      OWN1: begin
        bus.valid  = bus.req1;
        bus.Hwrite = bus.Hwrite1;
        bus.Haddr  = bus.Haddr1;
        bus.Hwdata = bus.Hwdata1;
        bus.ack1   = bus.req1 && bus.Hreadyout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench for apb_bridge_arbiter: MAX_BURST=4 and MAX_BURST=1 instances, queue scoreboard.
module tb_apb_bridge_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] D0 = 32'hA0A0_0001;
  localparam logic        W0 = 1'b1;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] D1 = 32'hB1B1_0002;
  localparam logic        W1 = 1'b0;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        valid;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        ack0;
    logic        ack1;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  apb_bridge_arbiter_if if4 ();
  apb_bridge_arbiter_if if1 ();

  apb_bridge_arbiter #(.MAX_BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  apb_bridge_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // expected bridge request: mux fields follow the owner regardless of req
  function automatic obs_t mk(logic [1:0] g, logic v, logic a0, logic a1);
    obs_t o;
    o.gnt   = g;
    o.valid = v;
    o.ack0  = a0;
    o.ack1  = a1;
    case (g)
      2'b01:   begin o.hwrite = W0; o.haddr = A0; o.hwdata = D0; end
      2'b10:   begin o.hwrite = W1; o.haddr = A1; o.hwdata = D1; end
      default: begin o.hwrite = 1'b0; o.haddr = 32'd0; o.hwdata = 32'd0; end
    endcase
    return o;
  endfunction

  function automatic obs_t sample(bit which);
    obs_t o;
    if (which) begin
      o = {if1.gnt, if1.valid, if1.Hwrite, if1.Haddr, if1.Hwdata, if1.ack0, if1.ack1};
    end else begin
      o = {if4.gnt, if4.valid, if4.Hwrite, if4.Haddr, if4.Hwdata, if4.ack0, if4.ack1};
    end
    return o;
  endfunction

  task automatic drive(bit which, logic r0, logic r1, logic hr);
    if (which) begin
      if1.req0 = r0; if1.req1 = r1; if1.Hreadyout = hr;
    end else begin
      if4.req0 = r0; if4.req1 = r1; if4.Hreadyout = hr;
    end
  endtask

  task automatic push(string tag, obs_t e);
    exp_t x;
    x.tag = tag;
    x.val = e;
    q.push_back(x);
  endtask

  task automatic pop_check(bit which);
    exp_t x;
    obs_t got;
    n_total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty got=none expected=entry");
    end else begin
      x   = q.pop_front();
      got = sample(which);
      assert (got === x.val) n_pass++;
      else $error("FAIL %s got gnt=%b v=%b w=%b a=%h d=%h ack=%b%b expected gnt=%b v=%b w=%b a=%h d=%h ack=%b%b",
                  x.tag, got.gnt, got.valid, got.hwrite, got.haddr, got.hwdata, got.ack0, got.ack1,
                  x.val.gnt, x.val.valid, x.val.hwrite, x.val.haddr, x.val.hwdata, x.val.ack0, x.val.ack1);
    end
  endtask

  task automatic step(bit which, logic r0, logic r1, logic hr, string tag, obs_t e);
    @(posedge clk);
    #1;
    drive(which, r0, r1, hr);
    push(tag, e);
    @(negedge clk);
    pop_check(which);
  endtask

  initial begin
    rst = 1'b0;
    if4.Hwrite0 = W0; if4.Haddr0 = A0; if4.Hwdata0 = D0;
    if4.Hwrite1 = W1; if4.Haddr1 = A1; if4.Hwdata1 = D1;
    if1.Hwrite0 = W0; if1.Haddr0 = A0; if1.Hwdata0 = D0;
    if1.Hwrite1 = W1; if1.Haddr1 = A1; if1.Hwdata1 = D1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);

    #2;
    push("reset4", mk(2'b00, 0, 0, 0)); pop_check(0);
    push("reset1", mk(2'b00, 0, 0, 0)); pop_check(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    // single master grant, one-cycle latency, then release to IDLE
    step(0, 1, 0, 1, "g0_idle",       mk(2'b00, 0, 0, 0));
    step(0, 1, 0, 1, "g0_own",        mk(2'b01, 1, 1, 0));
    step(0, 0, 0, 1, "req0_drop",     mk(2'b01, 0, 0, 0));
    step(0, 0, 0, 1, "idle_after",    mk(2'b00, 0, 0, 0));

    // build cnt=2 in OWN0, then reset asynchronously mid-cycle
    step(0, 1, 0, 1, "rst_pre_idle",  mk(2'b00, 0, 0, 0));
    step(0, 1, 0, 1, "rst_own_a",     mk(2'b01, 1, 1, 0));
    step(0, 1, 0, 1, "rst_own_b",     mk(2'b01, 1, 1, 0));
    step(0, 1, 0, 1, "rst_own_c",     mk(2'b01, 1, 1, 0));
    #2;
    rst = 1'b0;
    if4.req1 = 1'b1;
    #1;
    push("rst_async", mk(2'b00, 0, 0, 0)); pop_check(0);
    @(posedge clk);
    #3 rst = 1'b1;

    // tie after reset goes to master0, then 4/4 bursts
    step(0, 1, 1, 1, "tie_own0_1",    mk(2'b01, 1, 1, 0));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, "burst0",   mk(2'b01, 1, 1, 0));
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, "burst1",   mk(2'b10, 1, 0, 1));
    step(0, 1, 1, 1, "burst0_again",  mk(2'b01, 1, 1, 0));

    // owner drops with other waiting: immediate handover, then bridge stall
    step(0, 0, 1, 1, "own0_release",  mk(2'b01, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, "busy_hold1", mk(2'b10, 1, 0, 0));
    step(0, 1, 1, 1, "busy_done",     mk(2'b10, 1, 0, 1));
    step(0, 0, 0, 1, "own1_drop",     mk(2'b10, 0, 0, 0));
    step(0, 0, 0, 1, "idle_end",      mk(2'b00, 0, 0, 0));

    // MAX_BURST=1: strict alternation, no bubbles
    step(1, 1, 1, 1, "mb1_idle",      mk(2'b00, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, "mb1_own0",    mk(2'b01, 1, 1, 0));
      step(1, 1, 1, 1, "mb1_own1",    mk(2'b10, 1, 0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_bridge_arbiter.md
APB_BRIDGE_ARBITER -- requirements
Module: apb_bridge_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, range 1..15: maximum number of consecutive accepted transfers per ownership when the other master is waiting.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0, req1  input  1 each  master transfer request; held high until acked.
REQ-005 SHALL have ports Hwrite0, Hwrite1  input  1 each  master direction, 1=write.
REQ-006 SHALL have ports Haddr0, Haddr1, Hwdata0, Hwdata1  input  32 each  master address and write data.
REQ-007 SHALL have port Hreadyout  input  1  bridge ready; a transfer is accepted on a rising edge with valid=1 and Hreadyout=1.
REQ-008 SHALL have ports valid, Hwrite  output  1 each, and Haddr, Hwdata  output  32 each: the shared bridge AHB-side request.
REQ-009 SHALL have port gnt  output  2  registered one-hot owner, bit0=master0, bit1=master1, 00=none.
REQ-010 SHALL have ports ack0, ack1  output  1 each  combinational accept strobe to the owning master.

Function
REQ-011 SHALL implement states IDLE, OWN0, OWN1; gnt = 00/01/10 respectively.
REQ-012 SHALL drive valid = (OWN0 && req0) || (OWN1 && req1); in OWNx, SHALL mux Hwrite/Haddr/Hwdata from master x; in IDLE, SHALL drive all four outputs to 0.
REQ-013 SHALL drive ackx = OWNx && reqx && Hreadyout; at most one ack high per cycle.
REQ-014 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the master not equal to last_owner; none -> IDLE. Grant costs one cycle: the first valid appears the cycle after req is seen.
REQ-015 last_owner (1 bit) SHALL update to x on every entry into OWNx.
REQ-016 burst counter cnt SHALL clear on every entry into OWNx and increment on each accepted transfer.
REQ-017 OWNx with Hreadyout=0: SHALL hold state, owner, cnt and mux selection. No switching while the bridge is busy.
REQ-018 OWNx, Hreadyout=1, reqx=1: on accept, if cnt+1==MAX_BURST and the other master requests -> OWNy with cnt=0; if cnt+1==MAX_BURST and no other request -> stay with cnt=0; otherwise stay with cnt+1.
REQ-019 OWNx, Hreadyout=1, reqx=0: if the other master requests -> OWNy; else -> IDLE.
REQ-020 On a switch from OWNx to OWNy, valid SHALL come from master y in the very next cycle, with no idle bubble.
REQ-021 With MAX_BURST=1 and both masters requesting continuously, ownership SHALL alternate on every accepted transfer.
REQ-022 Masters SHALL hold request fields stable while req is high and unacked; the arbiter does not register them.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, gnt=00, cnt=0, last_owner=1 (master0 wins the first tie), valid=0, Hwrite=0, Haddr=0, Hwdata=0, ack0=ack1=0.
REQ-024 Reset asserted mid-ownership SHALL abandon the transfer with no ack. After release, arbitration restarts from IDLE on the next rising edge.

Verification
REQ-025 Reset, then req0=1 with Haddr0=0x100 and Hreadyout=1 -> gnt=01 after 1 cycle, valid=1, Haddr=0x100, ack0=1 in that cycle.
REQ-026 Both req rise together after reset, Hreadyout=1, MAX_BURST=4 -> OWN0 for exactly 4 acks, then gnt=10 for 4 acks, then back to gnt=01.
REQ-027 OWN1 with Hreadyout=0 for 3 cycles while req0=1 -> gnt stays 10, Haddr stays Haddr1, no ack; on Hreadyout=1, ack1 fires.
REQ-028 OWN0, req0 drops while Hreadyout=1 and req1=0 -> IDLE next cycle, valid=0, Haddr=0.
REQ-029 rst pulsed low in OWN0 with cnt=2 -> gnt=00 asynchronously; after release with both req high -> gnt=01 (last_owner=1).
REQ-030 MAX_BURST=1, both req high, Hreadyout=1 -> gnt alternates 01,10,01,... with one ack per cycle and no cycle with valid=0.
